// File: rtl/vx_mem_bridge.sv
// Memory bridge: in-order request FIFO with an outstanding-read limit,
// plus a one-entry response register between memory and core.
module vx_mem_bridge #(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned TAG_WIDTH   = 8,
    parameter int unsigned SIZE_WIDTH  = 3,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned MAX_PENDING = 8
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic                               core_req_valid,
    input  logic                               core_req_rw,
    input  logic [DATA_WIDTH/8-1:0]            core_req_byteen,
    input  logic [SIZE_WIDTH-1:0]              core_req_size,
    input  logic [ADDR_WIDTH-1:0]              core_req_addr,
    input  logic [DATA_WIDTH-1:0]              core_req_data,
    input  logic [TAG_WIDTH-1:0]               core_req_tag,
    output logic                               core_req_ready,

    output logic                               mem_req_valid,
    output logic                               mem_req_rw,
    output logic [DATA_WIDTH/8-1:0]            mem_req_byteen,
    output logic [SIZE_WIDTH-1:0]              mem_req_size,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr,
    output logic [DATA_WIDTH-1:0]              mem_req_data,
    output logic [TAG_WIDTH-1:0]               mem_req_tag,
    input  logic                               mem_req_ready,

    input  logic                               mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]               mem_rsp_tag,
    output logic                               mem_rsp_ready,

    output logic                               core_rsp_valid,
    output logic [DATA_WIDTH-1:0]              core_rsp_data,
    output logic [TAG_WIDTH-1:0]               core_rsp_tag,
    input  logic                               core_rsp_ready,

    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
    output logic                               busy
);

    localparam int unsigned BE_W    = DATA_WIDTH / 8;
    localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned PEND_W  = $clog2(MAX_PENDING + 1);
    localparam int unsigned ENTRY_W = 1 + BE_W + SIZE_WIDTH + ADDR_WIDTH + DATA_WIDTH + TAG_WIDTH;

    logic [ENTRY_W-1:0]    fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [PEND_W-1:0]     pend_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [TAG_WIDTH-1:0]  rsp_tag_q;

    logic fifo_empty;
    logic fifo_full;
    logic enq;
    logic deq;
    logic rsp_fire;
    logic rsp_accept;
    logic pend_inc;
    logic pend_dec;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(QUEUE_DEPTH));

    assign {mem_req_rw, mem_req_byteen, mem_req_size,
            mem_req_addr, mem_req_data, mem_req_tag} = fifo_mem[rd_ptr];

    // Reads are throttled by the outstanding limit; writes never are, but
    // nothing can overtake a blocked head.
    assign mem_req_valid  = !fifo_empty && (mem_req_rw || (pend_q < PEND_W'(MAX_PENDING)));
    assign core_req_ready = !fifo_full;

    assign enq        = core_req_valid && !fifo_full;
    assign deq        = mem_req_valid && mem_req_ready;
    assign rsp_accept = rsp_valid_q && core_rsp_ready;
    assign rsp_fire   = mem_rsp_valid && mem_rsp_ready;
    assign pend_inc   = deq && !mem_req_rw;
    assign pend_dec   = rsp_accept && (pend_q != '0);

    assign mem_rsp_ready  = !rsp_valid_q || core_rsp_ready;
    assign core_rsp_valid = rsp_valid_q;
    assign core_rsp_data  = rsp_data_q;
    assign core_rsp_tag   = rsp_tag_q;
    assign pending_count  = pend_q;
    assign busy           = !fifo_empty || (pend_q != '0) || rsp_valid_q;

    // Control state: pointers, occupancy, outstanding reads, response valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            pend_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);

            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (!enq && deq) count <= count - CNT_W'(1);

            if (pend_inc && !pend_dec)      pend_q <= pend_q + PEND_W'(1);
            else if (!pend_inc && pend_dec) pend_q <= pend_q - PEND_W'(1);

            if (rsp_fire)            rsp_valid_q <= 1'b1;
            else if (core_rsp_ready) rsp_valid_q <= 1'b0;
        end
    end

    // Payload storage carries no reset; validity is tracked above.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= {core_req_rw, core_req_byteen, core_req_size,
                                 core_req_addr, core_req_data, core_req_tag};
        end
        if (rsp_fire) begin
            rsp_data_q <= mem_rsp_data;
            rsp_tag_q  <= mem_rsp_tag;
        end
    end

endmodule

// File: tb/tb_vx_mem_bridge.sv
// Testbench for vx_mem_bridge: directed scenarios plus a randomized run
// checked against a queue-based transaction model.
module tb_vx_mem_bridge;

    localparam int unsigned DW = 512;
    localparam int unsigned AW = 32;
    localparam int unsigned TW = 8;
    localparam int unsigned SW = 3;
    localparam int unsigned QD = 4;
    localparam int unsigned MP = 8;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned PW = $clog2(MP + 1);

    typedef struct packed {
        logic          rw;
        logic [BW-1:0] be;
        logic [SW-1:0] size;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } req_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req_valid, core_req_rw, core_req_ready;
    logic [BW-1:0] core_req_byteen;
    logic [SW-1:0] core_req_size;
    logic [AW-1:0] core_req_addr;
    logic [DW-1:0] core_req_data;
    logic [TW-1:0] core_req_tag;
    logic          mem_req_valid, mem_req_rw, mem_req_ready;
    logic [BW-1:0] mem_req_byteen;
    logic [SW-1:0] mem_req_size;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [TW-1:0] mem_req_tag;
    logic          mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic          core_rsp_valid, core_rsp_ready;
    logic [DW-1:0] core_rsp_data;
    logic [TW-1:0] core_rsp_tag;
    logic [PW-1:0] pending_count;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    vx_mem_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .SIZE_WIDTH(SW), .QUEUE_DEPTH(QD), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
        .core_req_byteen(core_req_byteen), .core_req_size(core_req_size),
        .core_req_addr(core_req_addr), .core_req_data(core_req_data),
        .core_req_tag(core_req_tag), .core_req_ready(core_req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_byteen(mem_req_byteen), .mem_req_size(mem_req_size),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
        .pending_count(pending_count), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic idle_inputs();
        core_req_valid  = 1'b0;
        core_req_rw     = 1'b0;
        core_req_byteen = '0;
        core_req_size   = '0;
        core_req_addr   = '0;
        core_req_data   = '0;
        core_req_tag    = '0;
        mem_req_ready   = 1'b0;
        mem_rsp_valid   = 1'b0;
        mem_rsp_data    = '0;
        mem_rsp_tag     = '0;
        core_rsp_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Hold a request until the bridge takes it (bounded).
    task automatic push(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        core_req_valid  = 1'b1;
        core_req_rw     = rw;
        core_req_addr   = addr;
        core_req_tag    = tag;
        core_req_byteen = {BW{1'b1}};
        core_req_size   = SW'(6);
        core_req_data   = {(DW/AW){addr}};
        for (int i = 0; i < 50; i++) begin
            if (core_req_ready === 1'b1) begin
                tick();
                core_req_valid = 1'b0;
                return;
            end
            tick();
        end
        core_req_valid = 1'b0;
        n_checks++; n_fail++;
        $display("FAIL push_timeout: addr %h not accepted within 50 cycles", addr);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
        n_checks++; if (core_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_core_req_ready got=%b exp=1", core_req_ready); end
        n_checks++; if (mem_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_rsp_ready got=%b exp=1", mem_rsp_ready); end
        n_checks++; if (core_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_core_rsp_valid got=%b exp=0", core_rsp_valid); end
        n_checks++; if (pending_count !== PW'(0)) begin n_fail++; $display("FAIL reset_pending got=%0d exp=0", pending_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic_read();
        logic [DW-1:0] d;
        do_reset();
        mem_req_ready  = 1'b1;
        core_req_valid = 1'b1;
        core_req_rw    = 1'b0;
        core_req_addr  = AW'(32'h100);
        core_req_tag   = TW'(8'h05);
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass got=%b exp=0", mem_req_valid); end
        tick();
        core_req_valid = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", mem_req_valid); end
        n_checks++; if (mem_req_addr !== AW'(32'h100)) begin n_fail++; $display("FAIL basic_addr got=%h exp=100", mem_req_addr); end
        n_checks++; if (mem_req_tag !== TW'(8'h05)) begin n_fail++; $display("FAIL basic_tag got=%h exp=05", mem_req_tag); end
        n_checks++; if (pending_count !== PW'(0)) begin n_fail++; $display("FAIL basic_pending_c1 got=%0d exp=0", pending_count); end
        tick();
        n_checks++; if (pending_count !== PW'(1)) begin n_fail++; $display("FAIL basic_pending_c2 got=%0d exp=1", pending_count); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got=%b exp=0", mem_req_valid); end
        d = rnd_data();
        mem_rsp_valid  = 1'b1;
        mem_rsp_tag    = TW'(8'h05);
        mem_rsp_data   = d;
        core_rsp_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (core_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rsp_valid got=%b exp=1", core_rsp_valid); end
        n_checks++; if (core_rsp_data !== d) begin n_fail++; $display("FAIL basic_rsp_data got=%h exp=%h", core_rsp_data, d); end
        n_checks++; if (core_rsp_tag !== TW'(8'h05)) begin n_fail++; $display("FAIL basic_rsp_tag got=%h exp=05", core_rsp_tag); end
        tick();
        n_checks++; if (pending_count !== PW'(0)) begin n_fail++; $display("FAIL basic_pending_end got=%0d exp=0", pending_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            core_req_valid = 1'b1;
            core_req_rw    = 1'(i % 2);
            core_req_addr  = AW'(32'h200 + i * 32'h40);
            core_req_tag   = TW'(i);
            n_checks++; if (core_req_ready !== (i < 4)) begin n_fail++; $display("FAIL full_ready_%0d got=%b exp=%b", i, core_req_ready, (i < 4)); end
            tick();
        end
        core_req_valid = 1'b0;
        mem_req_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid_%0d got=%b exp=1", i, mem_req_valid); end
            n_checks++; if (mem_req_addr !== AW'(32'h200 + i * 32'h40)) begin n_fail++; $display("FAIL full_out_addr_%0d got=%h exp=%h", i, mem_req_addr, 32'h200 + i * 32'h40); end
            n_checks++; if (mem_req_tag !== TW'(i)) begin n_fail++; $display("FAIL full_out_tag_%0d got=%h exp=%h", i, mem_req_tag, i); end
            tick();
        end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%b exp=0", mem_req_valid); end
        n_checks++; if (pending_count !== PW'(2)) begin n_fail++; $display("FAIL full_pending got=%0d exp=2", pending_count); end
    endtask

    task automatic test_read_limit();
        do_reset();
        mem_req_ready = 1'b1;
        for (int i = 0; i < int'(MP); i++) push(1'b0, AW'(32'h1000 + i * 64), TW'(i));
        push(1'b0, AW'(32'h9000), TW'(8'h99));
        push(1'b1, AW'(32'hA000), TW'(8'hAA));
        repeat (3) tick();
        n_checks++; if (pending_count !== PW'(MP)) begin n_fail++; $display("FAIL lim_pending got=%0d exp=%0d", pending_count, MP); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL lim_blocked got=%b exp=0", mem_req_valid); end
        n_checks++; if (mem_req_addr !== AW'(32'h9000)) begin n_fail++; $display("FAIL lim_head got=%h exp=9000", mem_req_addr); end
        mem_rsp_valid  = 1'b1;
        mem_rsp_tag    = '0;
        core_rsp_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL lim_still_blocked got=%b exp=0", mem_req_valid); end
        tick();
        n_checks++; if (pending_count !== PW'(MP - 1)) begin n_fail++; $display("FAIL lim_pending_dec got=%0d exp=%0d", pending_count, MP - 1); end
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== AW'(32'h9000)) begin n_fail++; $display("FAIL lim_9th_issue got=%b/%h exp=1/9000", mem_req_valid, mem_req_addr); end
        tick();
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== AW'(32'hA000)) begin n_fail++; $display("FAIL lim_write_issue got=%b/%b/%h exp=1/1/a000", mem_req_valid, mem_req_rw, mem_req_addr); end
        n_checks++; if (pending_count !== PW'(MP)) begin n_fail++; $display("FAIL lim_pending_full got=%0d exp=%0d", pending_count, MP); end
        tick();
        n_checks++; if (pending_count !== PW'(MP)) begin n_fail++; $display("FAIL lim_write_no_count got=%0d exp=%0d", pending_count, MP); end
    endtask

    task automatic test_rsp_backpressure();
        logic [DW-1:0] a5;
        a5 = {BW{8'hA5}};
        do_reset();
        mem_req_ready = 1'b1;
        push(1'b0, AW'(32'h300), TW'(3));
        tick();
        n_checks++; if (pending_count !== PW'(1)) begin n_fail++; $display("FAIL bp_pending got=%0d exp=1", pending_count); end
        mem_rsp_valid  = 1'b1;
        mem_rsp_tag    = TW'(3);
        mem_rsp_data   = a5;
        core_rsp_ready = 1'b0;
        tick();
        mem_rsp_tag  = TW'(7);
        mem_rsp_data = ~a5;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (core_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d got=%b exp=1", i, core_rsp_valid); end
            n_checks++; if (core_rsp_data !== a5 || core_rsp_tag !== TW'(3)) begin n_fail++; $display("FAIL bp_stable_%0d got tag=%h exp=03", i, core_rsp_tag); end
            n_checks++; if (mem_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL bp_mem_rsp_ready_%0d got=%b exp=0", i, mem_rsp_ready); end
            tick();
        end
        mem_rsp_valid  = 1'b0;
        core_rsp_ready = 1'b1;
        #1;
        n_checks++; if (mem_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release got=%b exp=1", mem_rsp_ready); end
        tick();
        n_checks++; if (core_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accepted got=%b exp=0", core_rsp_valid); end
        n_checks++; if (pending_count !== PW'(0)) begin n_fail++; $display("FAIL bp_pending_dec got=%0d exp=0", pending_count); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        mem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b0, AW'(32'h4000 + i * 64), TW'(i));
        tick();
        n_checks++; if (pending_count !== PW'(3)) begin n_fail++; $display("FAIL same_pending_pre got=%0d exp=3", pending_count); end
        mem_req_ready = 1'b0;
        push(1'b0, AW'(32'h5000), TW'(4));
        mem_rsp_valid  = 1'b1;
        core_rsp_ready = 1'b0;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (core_rsp_valid !== 1'b1 || mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL same_setup got rsp=%b req=%b exp=1/1", core_rsp_valid, mem_req_valid); end
        core_rsp_ready = 1'b1;
        mem_req_ready  = 1'b1;
        tick();
        n_checks++; if (pending_count !== PW'(3)) begin n_fail++; $display("FAIL same_pending_post got=%0d exp=3", pending_count); end
        n_checks++; if (core_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL same_both_fired got rsp=%b req=%b exp=0/0", core_rsp_valid, mem_req_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        core_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_rsp_valid = (i < 4);
            mem_rsp_tag   = TW'(8'h10 + i);
            #1;
            n_checks++; if (mem_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, mem_rsp_ready); end
            if (i > 0) begin
                n_checks++; if (core_rsp_valid !== 1'b1 || core_rsp_tag !== TW'(8'h10 + i - 1)) begin n_fail++; $display("FAIL b2b_rsp_%0d got=%b/%h exp=1/%h", i, core_rsp_valid, core_rsp_tag, 8'h10 + i - 1); end
            end
            tick();
        end
        n_checks++; if (core_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", core_rsp_valid); end
        n_checks++; if (pending_count !== PW'(0)) begin n_fail++; $display("FAIL b2b_no_underflow got=%0d exp=0", pending_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_req_ready = 1'b1;
        push(1'b0, AW'(32'h600), TW'(1));
        tick();
        mem_req_ready = 1'b0;
        push(1'b0, AW'(32'h640), TW'(2));
        push(1'b1, AW'(32'h680), TW'(3));
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = TW'(9);
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || core_rsp_valid !== 1'b1 || mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup got busy=%b rsp=%b req=%b exp=1/1/1", busy, core_rsp_valid, mem_req_valid); end
        reset = 1'b1;
        tick();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid got=%b exp=0", mem_req_valid); end
        n_checks++; if (core_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid got=%b exp=0", core_rsp_valid); end
        n_checks++; if (pending_count !== PW'(0)) begin n_fail++; $display("FAIL mid_pending got=%0d exp=0", pending_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
        n_checks++; if (core_req_ready !== 1'b1 || mem_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL mid_readies got=%b/%b exp=1/1", core_req_ready, mem_rsp_ready); end
        reset = 1'b0;
        tick();
        n_checks++; if (mem_req_valid !== 1'b0 || core_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_pulse got=%b/%b exp=0/0", mem_req_valid, core_rsp_valid); end
    endtask

    // Transaction-level model: a request queue, an outstanding-read
    // counter, and a single held response.
    task automatic test_random();
        req_t          q[$];
        req_t          nr;
        req_t          head;
        int            pend;
        logic          rv;
        logic [DW-1:0] rdata;
        logic [TW-1:0] rtag;
        logic          e_creq_ready, e_mreq_valid, e_mrsp_ready, e_busy;
        logic          enq, deq, acc, fire;
        do_reset();
        pend  = 0;
        rv    = 1'b0;
        rdata = '0;
        rtag  = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            nr.rw   = 1'($urandom_range(0, 2) == 0);
            nr.be   = {$urandom(), $urandom()};
            nr.size = SW'($urandom());
            nr.addr = AW'($urandom());
            nr.data = rnd_data();
            nr.tag  = TW'($urandom());
            core_req_valid  = 1'($urandom_range(0, 1));
            core_req_rw     = nr.rw;
            core_req_byteen = nr.be;
            core_req_size   = nr.size;
            core_req_addr   = nr.addr;
            core_req_data   = nr.data;
            core_req_tag    = nr.tag;
            mem_req_ready   = 1'($urandom_range(0, 3) != 0);
            mem_rsp_valid   = 1'($urandom_range(0, 3) == 0);
            mem_rsp_data    = rnd_data();
            mem_rsp_tag     = TW'($urandom());
            core_rsp_ready  = 1'($urandom_range(0, 3) != 0);
            #1;
            e_creq_ready = (q.size() < int'(QD));
            e_mreq_valid = (q.size() > 0) && (q[0].rw || pend < int'(MP));
            e_mrsp_ready = !rv || core_rsp_ready;
            e_busy       = (q.size() > 0) || (pend != 0) || rv;
            n_checks++; if (core_req_ready !== e_creq_ready) begin n_fail++; $display("FAIL rnd_core_req_ready cyc=%0d got=%b exp=%b", cyc, core_req_ready, e_creq_ready); end
            n_checks++; if (mem_req_valid !== e_mreq_valid) begin n_fail++; $display("FAIL rnd_mem_req_valid cyc=%0d got=%b exp=%b", cyc, mem_req_valid, e_mreq_valid); end
            if (e_mreq_valid) begin
                head = q[0];
                n_checks++; if ({mem_req_rw, mem_req_byteen, mem_req_size, mem_req_addr, mem_req_data, mem_req_tag} !== head) begin n_fail++; $display("FAIL rnd_mem_req_payload cyc=%0d got addr=%h tag=%h exp addr=%h tag=%h", cyc, mem_req_addr, mem_req_tag, head.addr, head.tag); end
            end
            n_checks++; if (pending_count !== PW'(pend)) begin n_fail++; $display("FAIL rnd_pending cyc=%0d got=%0d exp=%0d", cyc, pending_count, pend); end
            n_checks++; if (core_rsp_valid !== rv) begin n_fail++; $display("FAIL rnd_core_rsp_valid cyc=%0d got=%b exp=%b", cyc, core_rsp_valid, rv); end
            if (rv) begin
                n_checks++; if (core_rsp_data !== rdata || core_rsp_tag !== rtag) begin n_fail++; $display("FAIL rnd_core_rsp_payload cyc=%0d got tag=%h exp tag=%h", cyc, core_rsp_tag, rtag); end
            end
            n_checks++; if (mem_rsp_ready !== e_mrsp_ready) begin n_fail++; $display("FAIL rnd_mem_rsp_ready cyc=%0d got=%b exp=%b", cyc, mem_rsp_ready, e_mrsp_ready); end
            n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
            enq  = core_req_valid && e_creq_ready;
            deq  = e_mreq_valid && mem_req_ready;
            acc  = rv && core_rsp_ready;
            fire = mem_rsp_valid && e_mrsp_ready;
            if (deq && !q[0].rw) pend++;
            if (acc && pend > 0) pend--;
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(nr);
            if (fire) begin
                rv    = 1'b1;
                rdata = mem_rsp_data;
                rtag  = mem_rsp_tag;
            end else if (core_rsp_ready) begin
                rv = 1'b0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_read();
        test_fifo_full();
        test_read_limit();
        test_rsp_backpressure();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
